dll_lock_seq: RTL
=================

DLL_LOCK_SEQ -- requirements
Module: dll_lock_seq

Interface
REQ-001 Parameter TMO_W, default 16, width of timeout counter and cfg_timeout.
REQ-002 Parameter MAX_RETRY, default 3, retries after the first attempt before FAIL.
REQ-003 Parameter BACKOFF_CYC, default 8, cycles lock request is held low between attempts (>=1).
REQ-004 clk  input  1  sequencer clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  level enable; high starts and keeps lock sequence, low aborts to IDLE.
REQ-007 ms_nsl  input  1  1 = master side drives ms_* request, 0 = slave side drives sl_* request.
REQ-008 cfg_timeout  input  TMO_W  lock wait limit in clk cycles, sampled on REQ entry; 0 = wait forever.
REQ-009 ms_rx_dll_lock  input  1  master DLL lock status, asynchronous to clk.
REQ-010 sl_rx_dll_lock  input  1  slave DLL lock status, asynchronous to clk.
REQ-011 ms_rx_dll_lock_req  output  1  lock request to master DLL, registered.
REQ-012 sl_rx_dll_lock_req  output  1  lock request to slave DLL, registered.
REQ-013 lock_ok  output  1  registered, high while in LOCKED.
REQ-014 lock_fail  output  1  registered, high while in FAIL.
REQ-015 lock_lost  output  1  single-cycle pulse on lock loss in LOCKED.
REQ-016 retry_cnt  output  2  retries consumed in current sequence, saturating.
REQ-017 state  output  3  encoded FSM state: IDLE=0, REQ=1, LOCKED=2, BACKOFF=3, FAIL=4.

Function
REQ-018 Each lock input SHALL pass through a 2-flop synchronizer reset by rst_n; the selected synced lock (lk_s) is ms side when ms_nsl=1, else sl side.
REQ-019 Only the request selected by ms_nsl SHALL ever be high; the other is held 0.
REQ-020 IDLE: requests low; en=1 -> REQ, timeout counter cleared, cfg_timeout captured, retry_cnt cleared.
REQ-021 REQ: selected request high; counter increments each cycle; lk_s=1 -> LOCKED.
REQ-022 REQ: counter reaching captured timeout (nonzero) with lk_s=0 -> BACKOFF if retry_cnt<MAX_RETRY, else FAIL.
REQ-023 Lock and timeout in the same cycle: lock wins, -> LOCKED.
REQ-024 BACKOFF: request low for exactly BACKOFF_CYC cycles, then -> REQ with retry_cnt+1, counter cleared, cfg_timeout recaptured.
REQ-025 LOCKED: request stays high; lk_s falling -> lock_lost pulse for one cycle, -> REQ with retry_cnt cleared.
REQ-026 FAIL: request low, lock_fail high, held until en=0.
REQ-027 en=0 in any state SHALL force IDLE on next edge, requests low, lock_ok/lock_fail low next cycle.
REQ-028 Latency: lock input rising at edge N -> lk_s at N+2 -> lock_ok high after edge N+3.
REQ-029 ms_nsl change while not IDLE SHALL be ignored until IDLE is re-entered (latched on IDLE exit).

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, all outputs 0, synchronizers, counters and latched ms_nsl 0.
REQ-031 Reset release SHALL take effect on the first posedge clk with rst_n high; no sequence starts without en=1.

Configuration
REQ-032 Macro DLL_LOCK_SEQ_RETRY_EN defined: BACKOFF and retry behaviour per REQ-022/024.
REQ-033 Macro undefined: timeout in REQ goes directly to FAIL, BACKOFF unreachable, retry_cnt tied 0.

Verification
REQ-034 ms_nsl=1, en=1, cfg_timeout=20, ms lock rises 5 cycles after request -> lock_ok high 3 cycles after lock, sl_rx_dll_lock_req stays 0.
REQ-035 RETRY_EN defined, cfg_timeout=10, lock never rises -> 4 REQ windows of 10 cycles separated by 8 low cycles, retry_cnt 0..3, then lock_fail=1.
REQ-036 Macro undefined, cfg_timeout=10, no lock -> FAIL after first 10-cycle window, retry_cnt=0.
REQ-037 LOCKED, ms lock drops -> lock_lost pulse exactly one cycle, request stays high, re-lock returns to LOCKED with retry_cnt=0.
REQ-038 cfg_timeout=0, lock delayed 5000 cycles -> no timeout, LOCKED reached; en dropped mid-REQ -> IDLE next edge, request low.
REQ-039 rst_n asserted asynchronously mid-BACKOFF -> all outputs 0 immediately without clock edge.

Source files
------------

// File: rtl/dll_lock_seq_if.sv
// Handshake bundle between a lock controller and dll_lock_seq.
// master drives enable/config/DLL status; slave (the sequencer) drives requests and status.
interface dll_lock_seq_if #(
  parameter int unsigned TMO_W = 16
);
  logic             en;
  logic             ms_nsl;
  logic [TMO_W-1:0] cfg_timeout;
  logic             ms_rx_dll_lock;
  logic             sl_rx_dll_lock;
  logic             ms_rx_dll_lock_req;
  logic             sl_rx_dll_lock_req;
  logic             lock_ok;
  logic             lock_fail;
  logic             lock_lost;
  logic [1:0]       retry_cnt;
  logic [2:0]       state;

  modport master (
    output en, ms_nsl, cfg_timeout, ms_rx_dll_lock, sl_rx_dll_lock,
    input  ms_rx_dll_lock_req, sl_rx_dll_lock_req, lock_ok, lock_fail,
    input  lock_lost, retry_cnt, state
  );

  modport slave (
    input  en, ms_nsl, cfg_timeout, ms_rx_dll_lock, sl_rx_dll_lock,
    output ms_rx_dll_lock_req, sl_rx_dll_lock_req, lock_ok, lock_fail,
    output lock_lost, retry_cnt, state
  );
endinterface

// File: rtl/dll_lock_seq.sv
// DLL lock request sequencer: request, timeout, back-off/retry, lock-loss recovery.
// Define DLL_LOCK_SEQ_RETRY_EN to enable BACKOFF/retry; otherwise a timeout goes straight to FAIL.
module dll_lock_seq #(
  parameter int unsigned TMO_W       = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned BACKOFF_CYC = 8
) (
  input logic           clk,
  input logic           rst_n,
  dll_lock_seq_if.slave bus
);

`ifdef DLL_LOCK_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int unsigned RW = ($clog2(MAX_RETRY + 2) > 2) ? $clog2(MAX_RETRY + 2) : 2;
  localparam int unsigned BW = ($clog2(BACKOFF_CYC + 1) > 1) ? $clog2(BACKOFF_CYC + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BO_LAST   = BW'(BACKOFF_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  state_t           st;
  logic             ms_s1, ms_s2, sl_s1, sl_s2;
  logic             sel_ms;
  logic             lk_s;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_nxt;
  logic [TMO_W-1:0] tmo_cap;
  logic             tmo_hit;
  logic [BW-1:0]    bo_cnt;
  logic [RW-1:0]    retry;
  logic             ms_req_q, sl_req_q, lock_ok_q, lock_fail_q, lock_lost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_s1 <= 1'b0;
      ms_s2 <= 1'b0;
      sl_s1 <= 1'b0;
      sl_s2 <= 1'b0;
    end else begin
      ms_s1 <= bus.ms_rx_dll_lock;
      ms_s2 <= ms_s1;
      sl_s1 <= bus.sl_rx_dll_lock;
      sl_s2 <= sl_s1;
    end
  end

  always_comb begin
    lk_s    = sel_ms ? ms_s2 : sl_s2;
    cnt_nxt = cnt + TMO_W'(1);
    tmo_hit = (tmo_cap != '0) && (cnt_nxt == tmo_cap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      sel_ms      <= 1'b0;
      cnt         <= '0;
      tmo_cap     <= '0;
      bo_cnt      <= '0;
      retry       <= '0;
      ms_req_q    <= 1'b0;
      sl_req_q    <= 1'b0;
      lock_ok_q   <= 1'b0;
      lock_fail_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      if (!bus.en) begin
        st          <= ST_IDLE;
        ms_req_q    <= 1'b0;
        sl_req_q    <= 1'b0;
        lock_ok_q   <= 1'b0;
        lock_fail_q <= 1'b0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            // side selection is frozen here for the whole sequence
            sel_ms   <= bus.ms_nsl;
            cnt      <= '0;
            tmo_cap  <= bus.cfg_timeout;
            retry    <= '0;
            ms_req_q <= bus.ms_nsl;
            sl_req_q <= !bus.ms_nsl;
            st       <= ST_REQ;
          end
          ST_REQ: begin
            if (lk_s) begin
              lock_ok_q <= 1'b1;
              st        <= ST_LOCKED;
            end else if (tmo_hit) begin
              ms_req_q <= 1'b0;
              sl_req_q <= 1'b0;
              if (RETRY_EN && (retry < RETRY_MAX)) begin
                bo_cnt <= '0;
                st     <= ST_BACKOFF;
              end else begin
                lock_fail_q <= 1'b1;
                st          <= ST_FAIL;
              end
            end else begin
              cnt <= cnt_nxt;
            end
          end
          ST_LOCKED: begin
            if (!lk_s) begin
              lock_lost_q <= 1'b1;
              lock_ok_q   <= 1'b0;
              cnt         <= '0;
              tmo_cap     <= bus.cfg_timeout;
              retry       <= '0;
              st          <= ST_REQ;
            end
          end
          ST_BACKOFF: begin
            if (bo_cnt == BO_LAST) begin
              retry    <= retry + RW'(1);
              cnt      <= '0;
              tmo_cap  <= bus.cfg_timeout;
              ms_req_q <= sel_ms;
              sl_req_q <= !sel_ms;
              st       <= ST_REQ;
            end else begin
              bo_cnt <= bo_cnt + BW'(1);
            end
          end
          ST_FAIL: begin
            lock_fail_q <= 1'b1;
          end
          default: begin
            ms_req_q <= 1'b0;
            sl_req_q <= 1'b0;
            st       <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ms_rx_dll_lock_req = ms_req_q;
  assign bus.sl_rx_dll_lock_req = sl_req_q;
  assign bus.lock_ok            = lock_ok_q;
  assign bus.lock_fail          = lock_fail_q;
  assign bus.lock_lost          = lock_lost_q;
  assign bus.state              = st;
  assign bus.retry_cnt          = !RETRY_EN ? 2'd0 :
                                  (retry > RW'(3)) ? 2'd3 : retry[1:0];

endmodule
